// File: rtl/i2c_pkg.sv
// Shared constants and helpers for the i2c_ctrl family of blocks.
// Defaults describe the idle bus and the stock synchroniser/filter sizing.
package i2c_pkg;

  localparam int I2C_SYNC_STAGES_DEF = 2;
  localparam int I2C_FILT_W_DEF      = 4;
  localparam logic I2C_IDLE_LEVEL    = 1'b1;

  // Ceiling log2, minimum result 1 so it can size a select of a 1-entry thing.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/i2c_filt_ch.sv
// One filtered open-drain line: metastability chain, spike-rejection counter,
// registered level and registered 1-cycle edge strobes.
module i2c_filt_ch
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = I2C_SYNC_STAGES_DEF,
  parameter int FILT_W      = I2C_FILT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [FILT_W-1:0] i_filt_len,
  input  logic              i_line,
  output logic              o_line,
  output logic              o_rise,
  output logic              o_fall,
  output logic [FILT_W-1:0] o_cnt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [FILT_W-1:0]      cnt_q;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign o_cnt  = cnt_q;

  // The chain keeps sampling while the filter is frozen, so re-enable sees a fresh level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{I2C_IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_line};
    end
  end

  // A disagreeing level must win N+1 consecutive enabled edges; '>=' lets a
  // lowered threshold take effect on the very next edge instead of waiting for a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      o_line <= I2C_IDLE_LEVEL;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else if (!i_en) begin
      cnt_q  <= '0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else if (sync_s == o_line) begin
      cnt_q  <= '0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else if (cnt_q < i_filt_len) begin
      cnt_q  <= cnt_q + 1'b1;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      cnt_q  <= '0;
      o_line <= sync_s;
      o_rise <= sync_s;
      o_fall <= ~sync_s;
    end
  end

endmodule

// File: rtl/i2c_line_filter.sv
// Multi-channel synchroniser and glitch filter between the I2C pads and the
// bit/byte engines; each line is an independent i2c_filt_ch sharing enable and threshold.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int CH          = 2,
  parameter int SYNC_STAGES = I2C_SYNC_STAGES_DEF,
  parameter int FILT_W      = I2C_FILT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [FILT_W-1:0] i_filt_len,
  input  logic [CH-1:0]     i_line,
  output logic [CH-1:0]     o_line,
  output logic [CH-1:0]     o_rise,
  output logic [CH-1:0]     o_fall
);

  // Per-channel counters are kept visible inside the hierarchy for checker binding.
  logic [FILT_W-1:0] ch_cnt [CH];

  for (genvar g = 0; g < CH; g++) begin : g_ch
    i2c_filt_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (i_en),
      .i_filt_len (i_filt_len),
      .i_line     (i_line[g]),
      .o_line     (o_line[g]),
      .o_rise     (o_rise[g]),
      .o_fall     (o_fall[g]),
      .o_cnt      (ch_cnt[g])
    );
  end

endmodule
